// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: data window, RISC-V width codes,
// FSM state encoding and small helpers for access size and lane masks.
package lsu_pkg;

    localparam logic [31:0] DATA_BEGIN = 32'h1001_0000;
    localparam logic [31:0] DATA_END   = 32'h1001_3FFF;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, RESP} lsu_state_e;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] address;
        logic [63:0] wdata;
    } lsu_req_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] w);
        return 4'd1 << w;
    endfunction

    function automatic logic [7:0] base_mask(input logic [1:0] w);
        case (w)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic in_window(input logic [31:0] a);
        return (a >= DATA_BEGIN) && (a <= DATA_END);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake plus the doubleword data-memory port.
// master = core/memory side, slave = the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [63:0] req_write_data;

    logic        resp_valid;
    logic        resp_fault;
    logic [63:0] resp_data;

    logic [31:0] mem_address;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [7:0]  mem_byte_mask;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_write_data, mem_read_data,
        input  req_ready, resp_valid, resp_fault, resp_data,
               mem_address, mem_read_en, mem_write_en, mem_byte_mask, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_write_data, mem_read_data,
        output req_ready, resp_valid, resp_fault, resp_data,
               mem_address, mem_read_en, mem_write_en, mem_byte_mask, mem_write_data
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load formatter: merges up to two doublewords, extracts the
// addressed bytes and sign/zero-extends them to 64 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] lo_word,
    input  logic [63:0] hi_word,
    input  logic        split,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);
    logic [127:0] word128;
    logic [63:0]  shifted;

    always_comb begin
        // Unsplit accesses carry their only doubleword in hi_word.
        word128 = split ? {hi_word, lo_word} : {64'd0, hi_word};
        shifted = 64'(word128 >> {off, 3'b000});
        data    = shifted;
        case (funct3)
            F3_B:    data = {{56{shifted[7]}},  shifted[7:0]};
            F3_BU:   data = {56'd0,             shifted[7:0]};
            F3_H:    data = {{48{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {48'd0,             shifted[15:0]};
            F3_W:    data = {{32{shifted[31]}}, shifted[31:0]};
            F3_WU:   data = {32'd0,             shifted[31:0]};
            default: data = shifted;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request latch, window/width check, two-beat split issue
// to a doubleword memory port, and load result formatting.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    lsu_state_e  state;
    lsu_req_t    req_q;
    logic [7:0]  mask_hi_q;
    logic [63:0] lo_word;
    logic [63:0] load_data;

    logic [3:0]  size_in;
    logic [2:0]  off_in;
    logic [31:0] last_in;
    logic [15:0] mask_in;
    logic        fault_in;
    logic [2:0]  off_q;
    logic        split_q;

    assign size_in  = size_bytes(bus.req_funct3[1:0]);
    assign off_in   = bus.req_address[2:0];
    assign last_in  = bus.req_address + {28'd0, size_in} - 32'd1;
    // Upper byte of the 16-bit lane mask is the second beat; nonzero means split.
    assign mask_in  = {8'h00, base_mask(bus.req_funct3[1:0])} << off_in;
    assign fault_in = (bus.req_write ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111))
                    || !in_window(bus.req_address) || !in_window(last_in);
    assign off_q    = req_q.address[2:0];
    assign split_q  = |mask_hi_q;

    lsu_load_align u_align (
        .lo_word (lo_word),
        .hi_word (bus.mem_read_data),
        .split   (split_q),
        .off     (off_q),
        .funct3  (req_q.funct3),
        .data    (load_data)
    );

    assign bus.resp_data = (state == RESP && !req_q.write && !bus.resp_fault) ? load_data : 64'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            req_q              <= '0;
            mask_hi_q          <= '0;
            lo_word            <= '0;
            bus.req_ready      <= 1'b1;
            bus.resp_valid     <= 1'b0;
            bus.resp_fault     <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_read_en    <= 1'b0;
            bus.mem_write_en   <= 1'b0;
            bus.mem_byte_mask  <= '0;
            bus.mem_write_data <= '0;
        end else begin
            bus.mem_read_en    <= 1'b0;
            bus.mem_write_en   <= 1'b0;
            bus.mem_byte_mask  <= '0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.resp_valid     <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    req_q.write    <= bus.req_write;
                    req_q.funct3   <= bus.req_funct3;
                    req_q.address  <= bus.req_address;
                    req_q.wdata    <= bus.req_write_data;
                    mask_hi_q      <= mask_in[15:8];
                    bus.req_ready  <= 1'b0;
                    bus.resp_fault <= fault_in;
                    if (fault_in) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                    end else begin
                        state              <= ISSUE0;
                        bus.mem_address    <= {bus.req_address[31:3], 3'b000};
                        bus.mem_read_en    <= !bus.req_write;
                        bus.mem_write_en   <= bus.req_write;
                        bus.mem_byte_mask  <= mask_in[7:0];
                        bus.mem_write_data <= bus.req_write_data << {off_in, 3'b000};
                    end
                end
                ISSUE0: if (split_q) begin
                    state              <= ISSUE1;
                    bus.mem_address    <= {req_q.address[31:3], 3'b000} + 32'd8;
                    bus.mem_read_en    <= !req_q.write;
                    bus.mem_write_en   <= req_q.write;
                    bus.mem_byte_mask  <= mask_hi_q;
                    bus.mem_write_data <= req_q.wdata >> {4'd8 - {1'b0, off_q}, 3'b000};
                end else begin
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                end
                ISSUE1: begin
                    // First-beat read data arrives during the second beat.
                    lo_word        <= bus.mem_read_data;
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                end
                RESP: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory model, directed cases and
// randomized loads/stores checked cycle by cycle against a byte-wise reference.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int WIN = 16384;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] mem     [WIN];
    logic [7:0] ref_mem [WIN];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic win(input logic [31:0] a);
        return (a >= 32'h1001_0000) && (a <= 32'h1001_3FFF);
    endfunction

    function automatic logic [63:0] dev_word(input logic [31:0] dw);
        logic [63:0] w = '0;
        if (win(dw))
            for (int i = 0; i < 8; i++) w[8*i +: 8] = mem[int'(dw - 32'h1001_0000) + i];
        return w;
    endfunction

    // Data memory: read data one cycle after the strobe, masked byte writes.
    always @(posedge clk) begin
        if (bus.mem_read_en) bus.mem_read_data <= dev_word(bus.mem_address);
        if (bus.mem_write_en && win(bus.mem_address))
            for (int i = 0; i < 8; i++)
                if (bus.mem_byte_mask[i])
                    mem[int'(bus.mem_address - 32'h1001_0000) + i] = bus.mem_write_data[8*i +: 8];
    end

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        mem[int'(a - 32'h1001_0000)]     = b;
        ref_mem[int'(a - 32'h1001_0000)] = b;
    endtask

    task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [63:0] wd, input logic rst_mid,
                           output logic [63:0] rdata, output logic [7:0] m0, output logic [7:0] m1);
        int size, kr;
        logic fault, split, exp_rd, exp_wr, exp_resp, exp_rdy;
        logic [31:0] last, dw0, ba;
        logic [7:0]  em0, em1, exp_mask;
        logic [63:0] ed0, ed1, eload, lanes;
        size  = 1 << f3[1:0];
        last  = a + size - 1;
        fault = (wr && f3[2]) || (!wr && f3 == 3'b111) || !win(a) || !win(last);
        dw0   = {a[31:3], 3'b000};
        em0 = '0; em1 = '0; ed0 = '0; ed1 = '0; eload = '0;
        for (int i = 0; i < size; i++) begin
            ba = a + i;
            if ({ba[31:3], 3'b000} == dw0) begin
                em0[ba[2:0]] = 1'b1; ed0[8*ba[2:0] +: 8] = wd[8*i +: 8];
            end else begin
                em1[ba[2:0]] = 1'b1; ed1[8*ba[2:0] +: 8] = wd[8*i +: 8];
            end
        end
        split = (em1 != 0);
        if (fault) begin em0 = '0; em1 = '0; end
        kr = fault ? 1 : (split ? 3 : 2);
        if (!wr && !fault) begin
            for (int i = 0; i < size; i++) eload[8*i +: 8] = ref_mem[int'(a + i - 32'h1001_0000)];
            if (!f3[2] && size < 8 && eload[8*size-1])
                for (int j = size; j < 8; j++) eload[8*j +: 8] = 8'hFF;
        end
        rdata = '0; m0 = '0; m1 = '0;

        @(negedge clk);
        check("ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
        bus.req_address = a; bus.req_write_data = wd;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req_valid = 1'b0; bus.req_write = $urandom_range(0, 1);
                bus.req_funct3 = 3'($urandom); bus.req_address = $urandom;
                bus.req_write_data = {$urandom, $urandom};
            end
            exp_mask = (k == 1) ? em0 : ((k == 2 && split) ? em1 : 8'h00);
            exp_rd   = !wr && (exp_mask != 0);
            exp_wr   = wr && (exp_mask != 0);
            exp_resp = (k == kr) && !rst_mid;
            exp_rdy  = rst_mid ? (k >= 3) : (k > kr);
            check("rd_en", bus.mem_read_en, exp_rd);
            check("wr_en", bus.mem_write_en, exp_wr);
            check("mask", bus.mem_byte_mask, exp_mask);
            if (exp_mask != 0) begin
                check("addr", bus.mem_address, (k == 1) ? dw0 : dw0 + 32'd8);
                if (wr) begin
                    for (int i = 0; i < 8; i++) lanes[8*i +: 8] = {8{exp_mask[i]}};
                    check("wdata", bus.mem_write_data & lanes, ((k == 1) ? ed0 : ed1) & lanes);
                end
            end
            check("resp_valid", bus.resp_valid, exp_resp);
            check("ready", bus.req_ready, exp_rdy);
            if (exp_resp) begin
                check("resp_fault", bus.resp_fault, fault);
                check("resp_data", bus.resp_data, eload);
                rdata = bus.resp_data;
            end
            if (k == 1) m0 = bus.mem_byte_mask;
            if (k == 2) m1 = bus.mem_byte_mask;
            if (rst_mid && k == 2) reset = 1'b1;
            if (rst_mid && k == 3) reset = 1'b0;
        end
        // The memory saw both beats before reset landed, so the full store sticks.
        if (wr && !fault)
            for (int i = 0; i < size; i++) ref_mem[int'(a + i - 32'h1001_0000)] = wd[8*i +: 8];
    endtask

    logic [63:0] rd;
    logic [7:0]  m0, m1;
    logic [31:0] ra;
    int          diff;

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
        bus.req_address = '0; bus.req_write_data = '0;
        for (int i = 0; i < WIN; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.req_ready, 1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_fault", bus.resp_fault, 1'b0);
        check("rst_resp_data", bus.resp_data, 64'd0);
        check("rst_rd_en", bus.mem_read_en, 1'b0);
        check("rst_wr_en", bus.mem_write_en, 1'b0);
        check("rst_mask", bus.mem_byte_mask, 8'h00);
        check("rst_addr", bus.mem_address, 32'd0);
        check("rst_wdata", bus.mem_write_data, 64'd0);

        for (int i = 0; i < 8; i++) poke(32'h1001_0008 + i, 8'h11 * (i + 1));
        run_req(1'b0, 3'b011, 32'h1001_0008, '0, 1'b0, rd, m0, m1);
        check("ld_aligned", rd, 64'h8877_6655_4433_2211);
        check("ld_mask", m0, 8'hFF);

        poke(32'h1001_0003, 8'h80);
        run_req(1'b0, 3'b000, 32'h1001_0003, '0, 1'b0, rd, m0, m1);
        check("lb_data", rd, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_mask", m0, 8'h08);
        run_req(1'b0, 3'b100, 32'h1001_0003, '0, 1'b0, rd, m0, m1);
        check("lbu_data", rd, 64'h0000_0000_0000_0080);

        poke(32'h1001_0006, 8'h11); poke(32'h1001_0007, 8'h22);
        poke(32'h1001_0008, 8'h33); poke(32'h1001_0009, 8'h44);
        run_req(1'b0, 3'b010, 32'h1001_0006, '0, 1'b0, rd, m0, m1);
        check("lw_split_data", rd, 64'h0000_0000_4433_2211);
        check("lw_split_m0", m0, 8'hC0);
        check("lw_split_m1", m1, 8'h03);

        run_req(1'b1, 3'b011, 32'h1001_0005, 64'h0102_0304_0506_0708, 1'b0, rd, m0, m1);
        check("sd_split_m0", m0, 8'hE0);
        check("sd_split_m1", m1, 8'h1F);
        run_req(1'b0, 3'b011, 32'h1001_0005, '0, 1'b0, rd, m0, m1);
        check("sd_readback", rd, 64'h0102_0304_0506_0708);

        run_req(1'b1, 3'b010, 32'h1001_3FFE, 64'hDEAD_BEEF, 1'b0, rd, m0, m1);
        run_req(1'b1, 3'b100, 32'h1001_0000, 64'h55, 1'b0, rd, m0, m1);
        run_req(1'b0, 3'b111, 32'h1001_0010, '0, 1'b0, rd, m0, m1);
        run_req(1'b0, 3'b011, 32'h1000_FFFC, '0, 1'b0, rd, m0, m1);

        run_req(1'b1, 3'b011, 32'h1001_0103, {$urandom, $urandom}, 1'b1, rd, m0, m1);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                7:       ra = 32'h1001_0000 - $urandom_range(1, 8);
                8, 9:    ra = 32'h1001_3FF7 + $urandom_range(0, 12);
                default: ra = 32'h1001_0000 + $urandom_range(0, WIN - 1);
            endcase
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra,
                    {$urandom, $urandom}, 1'b0, rd, m0, m1);
        end

        diff = 0;
        for (int i = 0; i < WIN; i++) if (mem[i] !== ref_mem[i]) diff++;
        check("mem_image", 64'(diff), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
